// File: rtl/unidad_acceso_memoria.sv
// Load/store unit between the core FSM and data memory: sizes, byte strobes, extension, misalignment and wait-state timeout.
// One request outstanding; response 1 cycle after acceptance on error, 2+ cycles otherwise; memory-side outputs registered.
module unidad_acceso_memoria #(
    parameter int ANCHO_DIR  = 32,
    parameter int ANCHO_DAT  = 32,
    parameter int ESPERA_MAX = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sol_valida,
    output logic                   sol_lista,
    input  logic                   sol_escritura,
    input  logic [2:0]             sol_funct3,
    input  logic [ANCHO_DIR-1:0]   sol_dir,
    input  logic [ANCHO_DAT-1:0]   sol_dat,
    output logic                   resp_valida,
    output logic [ANCHO_DAT-1:0]   resp_dat,
    output logic [1:0]             resp_error,
    output logic                   mem_valida,
    input  logic                   mem_lista,
    output logic                   mem_escritura,
    output logic [ANCHO_DIR-1:0]   mem_dir,
    output logic [ANCHO_DAT/8-1:0] mem_bytes,
    output logic [ANCHO_DAT-1:0]   mem_dat_escritura,
    input  logic [ANCHO_DAT-1:0]   mem_dat_lectura
);

    localparam int NB   = ANCHO_DAT / 8;
    localparam int OFS  = $clog2(NB);
    localparam int CW   = $clog2(ESPERA_MAX + 1);
    localparam bit ES64 = (ANCHO_DAT == 64);

    localparam logic [1:0] REPOSO    = 2'd0;
    localparam logic [1:0] ACCESO    = 2'd1;
    localparam logic [1:0] RESPUESTA = 2'd2;

    logic [1:0]           estado;
    logic [CW-1:0]        cont;
    logic                 reg_escritura;
    logic [2:0]           reg_funct3;
    logic [OFS-1:0]       reg_ofs;

    logic                 f3_legal;
    logic                 desalineado;
    logic [3:0]           n_bytes;
    logic [NB-1:0]        tam_bytes;
    logic [ANCHO_DAT-1:0] mascara_dat;
    logic [OFS-1:0]       ofs;
    logic [NB-1:0]        bytes_desp;
    logic [ANCHO_DAT-1:0] dat_desp;
    logic [ANCHO_DIR-1:0] dir_alin;
    logic [ANCHO_DAT-1:0] lect_desp;
    logic [ANCHO_DAT-1:0] lect_ext;

    assign sol_lista = (estado == REPOSO) & reset;

    always_comb begin
        f3_legal = 1'b0;
        case (sol_funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b011:                 f3_legal = ES64;
            3'b100, 3'b101:         f3_legal = !sol_escritura;
            3'b110:                 f3_legal = !sol_escritura && ES64;
            default:                f3_legal = 1'b0;
        endcase
    end

    always_comb begin
        desalineado = 1'b0;
        case (sol_funct3[1:0])
            2'b01:   desalineado = sol_dir[0];
            2'b10:   desalineado = |sol_dir[1:0];
            2'b11:   desalineado = |sol_dir[2:0];
            default: desalineado = 1'b0;
        endcase
    end

    // Size mask built per lane so the same code serves 4- and 8-lane buses.
    assign n_bytes = 4'd1 << sol_funct3[1:0];
    always_comb begin
        tam_bytes   = '0;
        mascara_dat = '0;
        for (int i = 0; i < NB; i++) begin
            tam_bytes[i]          = (4'(i) < n_bytes);
            mascara_dat[8*i +: 8] = {8{tam_bytes[i]}};
        end
    end

    assign ofs        = sol_dir[OFS-1:0];
    assign bytes_desp = tam_bytes << ofs;
    assign dat_desp   = (sol_dat & mascara_dat) << {ofs, 3'b000};
    assign dir_alin   = {sol_dir[ANCHO_DIR-1:OFS], {OFS{1'b0}}};

    assign lect_desp = mem_dat_lectura >> {reg_ofs, 3'b000};

    always_comb begin
        lect_ext = lect_desp;
        case (reg_funct3)
            3'b000:  lect_ext = ANCHO_DAT'($signed(lect_desp[7:0]));
            3'b001:  lect_ext = ANCHO_DAT'($signed(lect_desp[15:0]));
            3'b010:  lect_ext = ANCHO_DAT'($signed(lect_desp[31:0]));
            3'b100:  lect_ext = ANCHO_DAT'(lect_desp[7:0]);
            3'b101:  lect_ext = ANCHO_DAT'(lect_desp[15:0]);
            3'b110:  lect_ext = ANCHO_DAT'(lect_desp[31:0]);
            default: lect_ext = lect_desp;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado            <= REPOSO;
            cont              <= '0;
            reg_escritura     <= 1'b0;
            reg_funct3        <= 3'b000;
            reg_ofs           <= '0;
            resp_valida       <= 1'b0;
            resp_dat          <= '0;
            resp_error        <= 2'b00;
            mem_valida        <= 1'b0;
            mem_escritura     <= 1'b0;
            mem_dir           <= '0;
            mem_bytes         <= '0;
            mem_dat_escritura <= '0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (sol_valida) begin
                        reg_escritura <= sol_escritura;
                        reg_funct3    <= sol_funct3;
                        reg_ofs       <= ofs;
                        if (!f3_legal || desalineado) begin
                            estado      <= RESPUESTA;
                            resp_valida <= 1'b1;
                            resp_dat    <= '0;
                            resp_error  <= f3_legal ? 2'b01 : 2'b11;
                        end else begin
                            estado            <= ACCESO;
                            cont              <= '0;
                            mem_valida        <= 1'b1;
                            mem_escritura     <= sol_escritura;
                            mem_dir           <= dir_alin;
                            mem_bytes         <= bytes_desp;
                            mem_dat_escritura <= dat_desp;
                        end
                    end
                end
                ACCESO: begin
                    if (mem_lista) begin
                        estado      <= RESPUESTA;
                        mem_valida  <= 1'b0;
                        resp_valida <= 1'b1;
                        resp_error  <= 2'b00;
                        resp_dat    <= reg_escritura ? '0 : lect_ext;
                    end else begin
                        cont <= cont + CW'(1);
                        if (cont == CW'(ESPERA_MAX - 1)) begin
                            estado      <= RESPUESTA;
                            mem_valida  <= 1'b0;
                            resp_valida <= 1'b1;
                            resp_error  <= 2'b10;
                            resp_dat    <= '0;
                        end
                    end
                end
                RESPUESTA: begin
                    resp_valida <= 1'b0;
                    estado      <= REPOSO;
                end
                default: estado <= REPOSO;
            endcase
        end
    end

endmodule
